// File: rtl/sd_spi_pkg.sv
// Shared definitions for the SD card SPI byte engine.
//   state_t         : FSM encoding IDLE/LOW/HIGH (2 bits)
//   HALF_FAST_DEF   : default sdclk half-period in clk cycles, normal speed
//   HALF_SLOW_DEF   : default sdclk half-period in clk cycles, card-init speed
//   SD_CLK_IDLE     : sd_clk level between transfers
//   SD_DI_IDLE      : sd_di (MOSI) level between transfers
//   DOUT_RST        : dout value after reset
package sd_spi_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOW  = 2'd1,
      HIGH = 2'd2
   } state_t;

   localparam int HALF_FAST_DEF = 1;
   localparam int HALF_SLOW_DEF = 64;

   localparam logic SD_CLK_IDLE = 1'b0;
   localparam logic SD_DI_IDLE  = 1'b1;

   localparam logic [7:0] DOUT_RST = 8'hFF;

endpackage

// File: rtl/sd_spi_clkdiv.sv
// Loadable half-period down-counter for the SD SPI clock.
//   clk   in  : clock, all logic on posedge
//   rst_n in  : asynchronous active-low reset
//   load  in  : restart the count for a new half-period
//   half  in  : half-period length in clk cycles (>=1)
//   tick  out : count has reached 0, i.e. the current half-period ends this cycle
// After load the count is half-1, so tick appears exactly `half` cycles later.
// The counter parks at 0 when not reloaded, so tick stays high while idle.
module sd_spi_clkdiv
   import sd_spi_pkg::*;
#(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] half,
   output logic         tick
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= half - W'(1);
      end else if (cnt != '0) begin
         cnt <= cnt - W'(1);
      end
   end

   assign tick = (cnt == '0);

endmodule

// File: rtl/sd_spi_master.sv
// SPI mode-0 byte engine for the SD card slot (fclk domain).
// One byte per start pulse: din is shifted out MSB-first on sd_di while sd_do
// is shifted in; the received byte appears on dout when busy falls.
// Chip select is handled elsewhere.
//   clk    in  : fclk, all logic on posedge
//   rst_n  in  : asynchronous active-low reset
//   start  in  : 1-clk pulse, begin a transfer (ignored while busy)
//   din    in  : byte to send, sampled on the start cycle
//   slow   in  : select HALF_SLOW (only with SD_SPI_SLOW_EN)
//   dout   out : last received byte, stable between transfers
//   busy   out : transfer in progress
//   sd_clk out : SPI clock, idles low
//   sd_di  out : MOSI, idles high
//   sd_do  in  : MISO
// Optional feature macro: SD_SPI_SLOW_EN enables the slow (card-init) clock
// selected by `slow`, latched on the start cycle and fixed for the byte.
// FSM state is held in `state` (state_t) for inspection.
module sd_spi_master
   import sd_spi_pkg::*;
#(
   parameter int HALF_FAST = HALF_FAST_DEF,
   parameter int HALF_SLOW = HALF_SLOW_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] din,
   input  logic       slow,
   output logic [7:0] dout,
   output logic       busy,
   output logic       sd_clk,
   output logic       sd_di,
   input  logic       sd_do
);

`ifdef SD_SPI_SLOW_EN
   localparam int DIV_W = $clog2(HALF_SLOW) + 1;
`else
   localparam int DIV_W = $clog2(HALF_FAST) + 1;
`endif

   localparam logic [DIV_W-1:0] HALF_F = DIV_W'(HALF_FAST);

   state_t           state;
   logic [7:0]       txrx;
   logic [2:0]       bitcnt;
   logic             rxbit;
   logic [DIV_W-1:0] half;
   logic             load;
   logic             tick;

`ifdef SD_SPI_SLOW_EN
   localparam logic [DIV_W-1:0] HALF_S = DIV_W'(HALF_SLOW);

   logic half_sel;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         half_sel <= 1'b0;
      end else if (state == IDLE && start) begin
         half_sel <= slow;
      end
   end

   // The first half-period is loaded on the start cycle itself, before
   // half_sel has captured slow, so use slow directly while idle.
   assign half = (((state == IDLE) ? slow : half_sel) != 1'b0) ? HALF_S : HALF_F;
`else
   logic unused_slow;
   assign unused_slow = slow;
   assign half        = HALF_F;
`endif

   // txrx[7] has already been driven onto sd_di when it shifts out.
   logic unused_txrx_msb;
   assign unused_txrx_msb = txrx[7];

   // Reload the divider at the start of every half-period except after the
   // final falling edge, so it parks at zero while idle.
   always_comb begin
      load = 1'b0;
      case (state)
         IDLE:    load = start;
         LOW:     load = tick;
         HIGH:    load = tick && (bitcnt != 3'd0);
         default: load = 1'b0;
      endcase
   end

   sd_spi_clkdiv #(
      .W (DIV_W)
   ) u_clkdiv (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load),
      .half  (half),
      .tick  (tick)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         txrx   <= '0;
         bitcnt <= 3'd7;
         rxbit  <= 1'b0;
         dout   <= DOUT_RST;
         busy   <= 1'b0;
         sd_clk <= SD_CLK_IDLE;
         sd_di  <= SD_DI_IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  txrx   <= din;
                  sd_di  <= din[7];
                  bitcnt <= 3'd7;
                  busy   <= 1'b1;
                  state  <= LOW;
               end
            end
            LOW: begin
               if (tick) begin
                  sd_clk <= 1'b1;
                  rxbit  <= sd_do;    // sample MISO on the rising edge
                  state  <= HIGH;
               end
            end
            HIGH: begin
               if (tick) begin
                  sd_clk <= SD_CLK_IDLE;
                  txrx   <= {txrx[6:0], rxbit};
                  if (bitcnt == 3'd0) begin
                     dout  <= {txrx[6:0], rxbit};
                     busy  <= 1'b0;
                     sd_di <= SD_DI_IDLE;
                     state <= IDLE;
                  end else begin
                     // next MOSI bit changes on the falling edge
                     sd_di  <= txrx[6];
                     bitcnt <= bitcnt - 3'd1;
                     state  <= LOW;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sd_spi_master.sv
// Testbench for sd_spi_master: randomized bytes exchanged with a behavioural
// SPI card model; expectations come from the byte values and half-period.
// Builds with or without SD_SPI_SLOW_EN.
module tb_sd_spi_master;

   localparam int H_FAST = 1;
   localparam int H_SLOW = 64;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [7:0] din;
   logic       slow;
   logic [7:0] dout;
   logic       busy;
   logic       sd_clk;
   logic       sd_di;
   logic       sd_do;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] exp_dout;        // byte dout must hold until the next completion
   logic [0:0] exp_q[$];        // MOSI bits the card expects, in order

   sd_spi_master #(
      .HALF_FAST (H_FAST),
      .HALF_SLOW (H_SLOW)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .din    (din),
      .slow   (slow),
      .dout   (dout),
      .busy   (busy),
      .sd_clk (sd_clk),
      .sd_di  (sd_di),
      .sd_do  (sd_do)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- checking ----------------
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic int exp_half(input logic s);
`ifdef SD_SPI_SLOW_EN
      return s ? H_SLOW : H_FAST;
`else
      return H_FAST;
`endif
   endfunction

   // ---------------- driver + card model ----------------
   // Starts a transfer of tx while the card answers rx, follows it to the
   // end and checks bits, timing and dout. rep >= 0 re-pulses start with
   // din=0 on that busy cycle; tog toggles slow during the byte.
   task automatic run_xfer(input logic [7:0] tx, input logic [7:0] rx,
                           input logic slw, input int rep, input logic tog);
      int   half;
      int   limit;
      int   busy_cnt;
      int   hi_cnt;
      int   rises;
      int   di_bad;
      int   hold_bad;
      int   idle_bad;
      int   rx_idx;
      logic prev_clk;
      logic prev_di;
      logic fell;

      half  = exp_half(slw);
      limit = 16 * half + 40;
      exp_q.delete();
      for (int i = 0; i < 8; i++) exp_q.push_back(tx[7-i]);

      din      = tx;
      slow     = slw;
      rx_idx   = 0;
      sd_do    = rx[7];
      start    = 1'b1;
      @(negedge clk);
      start    = 1'b0;
      din      = 8'($urandom);

      busy_cnt = 0;
      hi_cnt   = 0;
      rises    = 0;
      di_bad   = 0;
      hold_bad = 0;
      prev_clk = 1'b0;
      prev_di  = 1'b1;

      for (int cyc = 0; cyc < limit; cyc++) begin
         fell = prev_clk && !sd_clk;
         if (sd_clk && !prev_clk) begin
            rises++;
            if (exp_q.size() > 0) chk("mosi_bit", 32'(sd_di), 32'(exp_q.pop_front()));
         end
         if (fell) begin
            rx_idx++;
            if (rx_idx < 8) sd_do = rx[7-rx_idx];
         end
         if (sd_di !== prev_di && !fell && cyc != 0) di_bad++;
         prev_clk = sd_clk;
         prev_di  = sd_di;
         if (!busy) break;
         busy_cnt++;
         if (sd_clk) hi_cnt++;
         if (dout !== exp_dout) hold_bad++;
         if (cyc == rep) begin
            start = 1'b1;
            din   = 8'h00;
         end else begin
            start = 1'b0;
         end
         if (tog && (cyc % 100) == 50) slow = ~slow;
         @(negedge clk);
      end
      start = 1'b0;

      chk("xfer_done",   32'(busy), 32'd0);
      chk("busy_len",    32'(busy_cnt), 32'(16 * half));
      chk("sclk_high",   32'(hi_cnt), 32'(8 * half));
      chk("sclk_rises",  32'(rises), 32'd8);
      chk("di_stable",   32'(di_bad), 32'd0);
      chk("dout_hold",   32'(hold_bad), 32'd0);
      chk("dout_rx",     32'(dout), 32'(rx));
      chk("sclk_idle",   32'(sd_clk), 32'd0);
      chk("di_idle",     32'(sd_di), 32'd1);
      exp_dout = rx;

      if (rep >= 0) begin
         idle_bad = 0;
         repeat (4) begin
            @(negedge clk);
            if (busy || sd_clk) idle_bad++;
         end
         chk("no_second_xfer", 32'(idle_bad), 32'd0);
         chk("dout_kept", 32'(dout), 32'(rx));
      end
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic [7:0] tx;
      logic [7:0] rx;

      rst_n    = 1'b0;
      start    = 1'b0;
      din      = 8'h00;
      slow     = 1'b0;
      sd_do    = 1'b1;
      exp_dout = 8'hFF;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      chk("rst_dout",   32'(dout), 32'hFF);
      chk("rst_busy",   32'(busy), 32'd0);
      chk("rst_sd_clk", 32'(sd_clk), 32'd0);
      chk("rst_sd_di",  32'(sd_di), 32'd1);

      // basic byte with a known card reply
      run_xfer(8'hA5, 8'h3C, 1'b0, -1, 1'b0);

      // start re-pulsed mid-transfer is dropped
      run_xfer(8'h5A, 8'hC3, 1'b0, 4, 1'b0);

      // start landing on the edge busy falls is dropped
      run_xfer(8'h96, 8'h69, 1'b0, 15, 1'b0);

      // back-to-back: second start on the first idle cycle
      run_xfer(8'h11, 8'hEE, 1'b0, -1, 1'b0);
      run_xfer(8'h00, 8'h00, 1'b0, -1, 1'b0);

      // slow select (ignored unless the slow clock is built in)
      run_xfer(8'hFF, 8'($urandom), 1'b1, -1, 1'b1);

      // async reset mid-transfer
      run_xfer(8'h33, 8'h5A, 1'b0, -1, 1'b0);
      din   = 8'hA5;
      slow  = 1'b0;
      sd_do = 1'b1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (6) @(negedge clk);
      chk("pre_rst_busy", 32'(busy), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_sd_clk", 32'(sd_clk), 32'd0);
      chk("arst_sd_di",  32'(sd_di), 32'd1);
      chk("arst_busy",   32'(busy), 32'd0);
      chk("arst_dout",   32'(dout), 32'hFF);
      @(negedge clk);
      rst_n    = 1'b1;
      exp_dout = 8'hFF;
      @(negedge clk);
      run_xfer(8'hC6, 8'h6C, 1'b0, -1, 1'b0);

      // randomized bytes and speeds
      for (int k = 0; k < 10; k++) begin
         tx = 8'($urandom);
         rx = 8'($urandom);
         run_xfer(tx, rx, 1'($urandom_range(0, 1)), -1, 1'b0);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
